// File: rtl/bk_sub16_pipe.sv
// Two-stage Brent-Kung subtractor: diff = a - b - bin,
// built as a + ~b + ~bin with valid/ready streaming.
module bk_sub16_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  if (WIDTH != 16) begin : g_width_chk
    $error("bk_sub16_pipe: WIDTH must be 16");
  end

  // g1/p1 keep only the pairs the reverse tree needs
  typedef struct packed {
    logic [15:0] p;
    logic [7:0]  ge;
    logic        cin;
    logic [3:0]  g1;
    logic [3:0]  p1;
    logic [3:0]  g2;
    logic [3:0]  p2;
    logic        a15;
    logic        bb15;
  } s1_t;

  s1_t s1_d;
  s1_t s1_q;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  logic [15:0] bb;
  logic [15:0] pb;
  logic [15:0] gb;
  logic [7:0]  gl1;
  logic [7:0]  pl1;
  logic [3:0]  gl2;
  logic [3:0]  pl2;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  assign bb = ~b[15:0];
  assign pb = a[15:0] ^ bb;
  assign gb = a[15:0] & bb;

  always_comb begin
    gl1  = '0;
    pl1  = '0;
    gl2  = '0;
    pl2  = '0;
    s1_d = '0;
    for (int k = 0; k < 8; k++) begin
      gl1[k] = gb[2*k+1] | (pb[2*k+1] & gb[2*k]);
      pl1[k] = pb[2*k+1] & pb[2*k];
      s1_d.ge[k] = gb[2*k];
    end
    for (int q = 0; q < 4; q++) begin
      gl2[q] = gl1[2*q+1] | (pl1[2*q+1] & gl1[2*q]);
      pl2[q] = pl1[2*q+1] & pl1[2*q];
      s1_d.g1[q] = gl1[2*q];
      s1_d.p1[q] = pl1[2*q];
    end
    s1_d.p    = pb;
    s1_d.cin  = ~bin;
    s1_d.g2   = gl2;
    s1_d.p2   = pl2;
    s1_d.a15  = a[15];
    s1_d.bb15 = bb[15];
  end

  logic g3_lo, p3_lo, g3_hi, p3_hi, g4, p4;
  logic c0, c2, c4, c6, c8, c10, c12, c14, c16;
  logic [7:0]  ce;
  logic [7:0]  pe;
  logic [7:0]  co;
  logic [15:0] c;
  logic [15:0] diff_d;
  logic        ovf_d;

  assign g3_lo = s1_q.g2[1] | (s1_q.p2[1] & s1_q.g2[0]);
  assign p3_lo = s1_q.p2[1] & s1_q.p2[0];
  assign g3_hi = s1_q.g2[3] | (s1_q.p2[3] & s1_q.g2[2]);
  assign p3_hi = s1_q.p2[3] & s1_q.p2[2];
  assign g4    = g3_hi | (p3_hi & g3_lo);
  assign p4    = p3_hi & p3_lo;

  // reverse tree: groups down to pairs
  assign c0  = s1_q.cin;
  assign c4  = s1_q.g2[0] | (s1_q.p2[0] & c0);
  assign c8  = g3_lo | (p3_lo & c0);
  assign c16 = g4 | (p4 & c0);
  assign c12 = s1_q.g2[2] | (s1_q.p2[2] & c8);
  assign c2  = s1_q.g1[0] | (s1_q.p1[0] & c0);
  assign c6  = s1_q.g1[1] | (s1_q.p1[1] & c4);
  assign c10 = s1_q.g1[2] | (s1_q.p1[2] & c8);
  assign c14 = s1_q.g1[3] | (s1_q.p1[3] & c12);

  assign ce = {c14, c12, c10, c8, c6, c4, c2, c0};
  assign co = s1_q.ge | (pe & ce);

  always_comb begin
    pe = '0;
    c  = '0;
    for (int k = 0; k < 8; k++) begin
      pe[k]     = s1_q.p[2*k];
      c[2*k]    = ce[k];
      c[2*k+1]  = co[k];
    end
  end

  assign diff_d = s1_q.p ^ c;
  // same operand signs, different result sign
  assign ovf_d  = (s1_q.a15 == s1_q.bb15) && (diff_d[15] != s1_q.a15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (s1_adv)
        s1_valid <= in_valid;
      if (in_valid && s1_adv)
        s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      if (s2_adv)
        s2_valid <= s1_valid;
      if (s1_valid && s2_adv) begin
        diff <= diff_d;
        bout <= ~c16;
        ovf  <= ovf_d;
        zero <= ~|diff_d;
      end
    end
  end

endmodule
